// File: rtl/inst_fetch_arb.sv
// inst_fetch_arb: shares a single-ported, combinational-read instruction ROM
// between the IF fetch port and a debug/loader read port. IF has priority;
// a saturating wait counter forces a debug grant after MAX_WAIT denials.
module inst_fetch_arb #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,

    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_err,

    output logic              stallreq,

    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCED = 1'b1
    } arb_state_e;

    arb_state_e        state_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic [CNT_W-1:0]  wait_cnt_d;

    logic              force_dbg;
    logic              dbg_gnt_w;
    logic              if_gnt_w;
    logic [ADDR_W-1:0] sel_addr;
    logic              misaligned;

    logic              if_rvalid_q,  if_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q,   if_rdata_d;
    logic              if_err_q,     if_err_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_W-1:0] dbg_rdata_q,  dbg_rdata_d;
    logic              dbg_err_q,    dbg_err_d;

    // Grant decision: IF first unless debug has waited MAX_WAIT cycles
    always_comb begin
        force_dbg = dbg_req & (state_q == ST_FORCED);
        dbg_gnt_w = dbg_req & (force_dbg | ~if_req);
        if_gnt_w  = if_req & ~dbg_gnt_w;
    end

    // ROM drive: address of the winner, chip enable only when word aligned
    always_comb begin
        sel_addr   = ADDR_W'(0);
        if (dbg_gnt_w) begin
            sel_addr = dbg_addr;
        end else if (if_gnt_w) begin
            sel_addr = if_addr;
        end
        misaligned = (sel_addr[1:0] != 2'b00);
        rom_ce     = (if_gnt_w | dbg_gnt_w) & ~misaligned;
        rom_addr   = sel_addr;
    end

    // Wait counter next value: clear on idle or grant, count denials, saturate
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!dbg_req || dbg_gnt_w) begin
            wait_cnt_d = CNT_W'(0);
        end else if (wait_cnt_q < MAX_CNT) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // Response next values: granted side captures, other side drops rvalid
    always_comb begin
        if_rvalid_d  = if_gnt_w;
        if_rdata_d   = if_rdata_q;
        if_err_d     = if_err_q;
        dbg_rvalid_d = dbg_gnt_w;
        dbg_rdata_d  = dbg_rdata_q;
        dbg_err_d    = dbg_err_q;
        if (if_gnt_w) begin
            if_err_d   = misaligned;
            if_rdata_d = misaligned ? DATA_W'(0) : rom_inst;
        end
        if (dbg_gnt_w) begin
            dbg_err_d   = misaligned;
            dbg_rdata_d = misaligned ? DATA_W'(0) : rom_inst;
        end
    end

    // Starvation FSM: NORMAL while counting, FORCED once the count hits MAX_WAIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_NORMAL;
            wait_cnt_q <= CNT_W'(0);
        end else begin
            wait_cnt_q <= wait_cnt_d;
            state_q    <= (wait_cnt_d == MAX_CNT) ? ST_FORCED : ST_NORMAL;
        end
    end

    // Registered responses, one cycle after grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= DATA_W'(0);
            if_err_q     <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= DATA_W'(0);
            dbg_err_q    <= 1'b0;
        end else begin
            if_rvalid_q  <= if_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            if_err_q     <= if_err_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_rdata_q  <= dbg_rdata_d;
            dbg_err_q    <= dbg_err_d;
        end
    end

    assign if_gnt     = if_gnt_w;
    assign dbg_gnt    = dbg_gnt_w;
    assign stallreq   = if_req & ~if_gnt_w;
    assign if_rvalid  = if_rvalid_q;
    assign if_rdata   = if_rdata_q;
    assign if_err     = if_err_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign dbg_err    = dbg_err_q;

endmodule
